// File: rtl/stat_cnt_rmw_pkg.sv
// Shared types and constants for the statistics-counter RMW engine.
package stat_cnt_rmw_pkg;

    // Operation carried down the read-modify-write pipeline.
    typedef enum logic [1:0] {
        OP_INC   = 2'd0,
        OP_RD    = 2'd1,
        OP_RDCLR = 2'd2
    } op_e;

    // Engine control state.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Consecutive increment grants a pending CPU request tolerates before it forces a slot.
    localparam int unsigned CPU_MAXWAIT = 4;
    localparam int unsigned WAITBIT     = $clog2(CPU_MAXWAIT + 1);

endpackage

// File: rtl/stat_cnt_rmw_if.sv
// Client-side bus of the RMW engine: increment stream, CPU access and init control.
interface stat_cnt_rmw_if #(
    parameter int unsigned ADDRBIT = 11,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned INCBIT  = 16
);
    logic               inc_vld;
    logic [ADDRBIT-1:0] inc_addr;
    logic [INCBIT-1:0]  inc_val;
    logic               inc_rdy;

    logic               cpu_req;
    logic               cpu_clr;
    logic [ADDRBIT-1:0] cpu_addr;
    logic               cpu_ack;
    logic [WIDTH-1:0]   cpu_rdata;

    logic               init_start;
    logic               init_busy;

    modport master (
        output inc_vld, inc_addr, inc_val, cpu_req, cpu_clr, cpu_addr, init_start,
        input  inc_rdy, cpu_ack, cpu_rdata, init_busy
    );

    modport slave (
        input  inc_vld, inc_addr, inc_val, cpu_req, cpu_clr, cpu_addr, init_start,
        output inc_rdy, cpu_ack, cpu_rdata, init_busy
    );
endinterface

// File: rtl/stat_cnt_rmw_fwd.sv
// Two-entry write history covering the array's read-after-write blind window, plus the
// priority select that produces the effective "old" counter value at S2.
module stat_cnt_fwd #(
    parameter int unsigned ADDRBIT = 11,
    parameter int unsigned WIDTH   = 32
) (
    input  logic               clk1x,
    input  logic               rst1x_,
    input  logic               wr_en,
    input  logic [ADDRBIT-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [ADDRBIT-1:0] rd_addr,
    input  logic [WIDTH-1:0]   mem_data,
    output logic [WIDTH-1:0]   old_data
);
    // h1 holds last cycle's write, h2 the write from the cycle before that.
    logic               h1_vld_q, h1_vld_d, h2_vld_q, h2_vld_d;
    logic [ADDRBIT-1:0] h1_addr_q, h1_addr_d, h2_addr_q, h2_addr_d;
    logic [WIDTH-1:0]   h1_data_q, h1_data_d, h2_data_q, h2_data_d;

    // Shift a new entry in every cycle; idle/read cycles push an invalid entry.
    always_comb begin
        h1_vld_d  = wr_en;
        h1_addr_d = wr_addr;
        h1_data_d = wr_data;
        h2_vld_d  = h1_vld_q;
        h2_addr_d = h1_addr_q;
        h2_data_d = h1_data_q;
    end

    // History registers.
    always_ff @(posedge clk1x or negedge rst1x_) begin
        if (!rst1x_) begin
            h1_vld_q  <= 1'b0;
            h1_addr_q <= '0;
            h1_data_q <= '0;
            h2_vld_q  <= 1'b0;
            h2_addr_q <= '0;
            h2_data_q <= '0;
        end else begin
            h1_vld_q  <= h1_vld_d;
            h1_addr_q <= h1_addr_d;
            h1_data_q <= h1_data_d;
            h2_vld_q  <= h2_vld_d;
            h2_addr_q <= h2_addr_d;
            h2_data_q <= h2_data_d;
        end
    end

    // Newest matching write wins over older history and over the array data.
    always_comb begin
        old_data = mem_data;
        if (h1_vld_q && (h1_addr_q == rd_addr)) begin
            old_data = h1_data_q;
        end else if (h2_vld_q && (h2_addr_q == rd_addr)) begin
            old_data = h2_data_q;
        end
    end

endmodule

// File: rtl/stat_cnt_rmw.sv
// Statistics-counter read-modify-write engine: arbitrates increments and CPU accesses onto
// array port 1 (2-clock read), saturating add with forwarding, and table zeroing on port 2.
module stat_cnt_rmw
    import stat_cnt_rmw_pkg::*;
#(
    parameter int unsigned ADDRBIT = 11,
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned INCBIT  = 16
) (
    input  logic               clk1x,
    input  logic               rst1x_,
    stat_cnt_rmw_if.slave      bus,
    output logic [ADDRBIT-1:0] ra1,
    output logic               re1,
    output logic [ADDRBIT-1:0] wa1,
    output logic               we1,
    output logic [WIDTH-1:0]   di1,
    input  logic [WIDTH-1:0]   do1,
    output logic [ADDRBIT-1:0] ra2,
    output logic               re2,
    output logic [ADDRBIT-1:0] wa2,
    output logic               we2,
    output logic [WIDTH-1:0]   di2
);
    state_e             state_q;
    logic               we2_q;
    logic [ADDRBIT-1:0] wa2_q;

    logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    op_e                s1_op_q, s1_op_d, s2_op_q, s2_op_d;
    logic [ADDRBIT-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
    logic [INCBIT-1:0]  s1_amt_q, s1_amt_d, s2_amt_q, s2_amt_d;
    logic [WAITBIT-1:0] wait_q, wait_d;
    logic               cpu_busy_q, cpu_busy_d;

    logic               cpu_pend, force_cpu, slot_open, inc_rdy, inc_go, cpu_go;
    logic [WIDTH-1:0]   old_val, sat_val;
    logic [WIDTH:0]     sum_wide;
    logic               wr_en, ack;

    // Control FSM: sweeps port 2 over the table, runs, and drains the pipe before re-init.
    always_ff @(posedge clk1x or negedge rst1x_) begin
        if (!rst1x_) begin
            state_q <= ST_INIT;
            we2_q   <= 1'b0;
            wa2_q   <= '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    if (!we2_q) begin
                        we2_q <= 1'b1;
                        wa2_q <= '0;
                    end else if (wa2_q == ADDRBIT'(DEPTH - 1)) begin
                        we2_q   <= 1'b0;
                        wa2_q   <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        wa2_q <= wa2_q + ADDRBIT'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.init_start) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!s1_vld_q && !s2_vld_q) state_q <= ST_INIT;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Slot arbitration: increments first, unless a CPU request has been starved long enough.
    always_comb begin
        cpu_pend  = bus.cpu_req && !cpu_busy_q;
        force_cpu = cpu_pend && (wait_q == WAITBIT'(CPU_MAXWAIT));
        slot_open = (state_q == ST_RUN) && !bus.init_start;
        inc_rdy   = slot_open && !force_cpu;
        inc_go    = bus.inc_vld && inc_rdy;
        cpu_go    = slot_open && cpu_pend && (force_cpu || !bus.inc_vld);
    end

    // S2 merge: forwarded old value, saturating add, write-back and CPU response.
    always_comb begin
        sum_wide = {1'b0, old_val} + (WIDTH + 1)'(s2_amt_q);
        sat_val  = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
        wr_en    = s2_vld_q && (s2_op_q != OP_RD);
        ack      = s2_vld_q && (s2_op_q != OP_INC);
    end

    // Pipeline, starvation counter and CPU-in-flight next state.
    always_comb begin
        s1_vld_d  = inc_go || cpu_go;
        s1_op_d   = inc_go ? OP_INC : (bus.cpu_clr ? OP_RDCLR : OP_RD);
        s1_addr_d = inc_go ? bus.inc_addr : bus.cpu_addr;
        s1_amt_d  = inc_go ? bus.inc_val : '0;
        s2_vld_d  = s1_vld_q;
        s2_op_d   = s1_op_q;
        s2_addr_d = s1_addr_q;
        s2_amt_d  = s1_amt_q;

        wait_d = wait_q;
        if (cpu_go || !cpu_pend) begin
            wait_d = '0;
        end else if (inc_go) begin
            wait_d = wait_q + WAITBIT'(1);
        end

        // The request is consumed at issue; it stays masked until its ack.
        cpu_busy_d = cpu_busy_q;
        if (cpu_go) begin
            cpu_busy_d = 1'b1;
        end else if (ack) begin
            cpu_busy_d = 1'b0;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk1x or negedge rst1x_) begin
        if (!rst1x_) begin
            s1_vld_q   <= 1'b0;
            s1_op_q    <= OP_INC;
            s1_addr_q  <= '0;
            s1_amt_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_op_q    <= OP_INC;
            s2_addr_q  <= '0;
            s2_amt_q   <= '0;
            wait_q     <= '0;
            cpu_busy_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_op_q    <= s1_op_d;
            s1_addr_q  <= s1_addr_d;
            s1_amt_q   <= s1_amt_d;
            s2_vld_q   <= s2_vld_d;
            s2_op_q    <= s2_op_d;
            s2_addr_q  <= s2_addr_d;
            s2_amt_q   <= s2_amt_d;
            wait_q     <= wait_d;
            cpu_busy_q <= cpu_busy_d;
        end
    end

    stat_cnt_fwd #(
        .ADDRBIT (ADDRBIT),
        .WIDTH   (WIDTH)
    ) u_fwd (
        .clk1x    (clk1x),
        .rst1x_   (rst1x_),
        .wr_en    (wr_en),
        .wr_addr  (wa1),
        .wr_data  (di1),
        .rd_addr  (s2_addr_q),
        .mem_data (do1),
        .old_data (old_val)
    );

    // Array and bus outputs; idle fields are forced to zero.
    always_comb begin
        re1 = s1_vld_d;
        ra1 = s1_vld_d ? s1_addr_d : '0;
        we1 = wr_en;
        wa1 = wr_en ? s2_addr_q : '0;
        di1 = (wr_en && (s2_op_q == OP_INC)) ? sat_val : '0;
        re2 = 1'b0;
        ra2 = '0;
        we2 = we2_q;
        wa2 = wa2_q;
        di2 = '0;
        bus.inc_rdy   = inc_rdy;
        bus.cpu_ack   = ack;
        bus.cpu_rdata = ack ? old_val : '0;
        bus.init_busy = (state_q != ST_RUN);
    end

endmodule

// File: tb/tb_stat_cnt_rmw.sv
// Directed bench for stat_cnt_rmw with a 2-clock-latency array model.
module tb_stat_cnt_rmw;
    localparam int unsigned ADDRBIT = 11;
    localparam int unsigned DEPTH   = 2048;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned INCBIT  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stat_cnt_rmw_if #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH), .INCBIT(INCBIT)) bus ();

    logic [ADDRBIT-1:0] ra1, wa1, ra2, wa2;
    logic               re1, we1, re2, we2;
    logic [WIDTH-1:0]   di1, di2, do1;

    stat_cnt_rmw #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .INCBIT  (INCBIT)
    ) dut (
        .clk1x  (clk),
        .rst1x_ (rst_n),
        .bus    (bus),
        .ra1    (ra1),
        .re1    (re1),
        .wa1    (wa1),
        .we1    (we1),
        .di1    (di1),
        .do1    (do1),
        .ra2    (ra2),
        .re2    (re2),
        .wa2    (wa2),
        .we2    (we2),
        .di2    (di2)
    );

    // Array model: reads sample before same-cycle writes, data returns two clocks later.
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [WIDTH-1:0]   rd_q;
    logic               fill, bd_we;
    logic [ADDRBIT-1:0] bd_addr;
    logic [WIDTH-1:0]   bd_data;

    always @(posedge clk) begin
        if (fill) for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD_0000 + 32'(i);
        if (bd_we) mem[bd_addr] <= bd_data;
        if (re1) rd_q <= mem[ra1];
        do1 <= rd_q;
        if (we1) mem[wa1] <= di1;
        if (we2) mem[wa2] <= di2;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe an init sweep until init_busy drops; optionally pulse init_start mid-sweep.
    task automatic wait_init(input int pulse_at, output int cnt, output int bad,
                             output logic done);
        int exp;
        exp = 0; cnt = 0; bad = 0; done = 1'b0;
        for (int n = 0; n < 2200 && !done; n++) begin
            bus.init_start = (n == pulse_at);
            @(negedge clk);
            if (!bus.init_busy) begin
                done = 1'b1;
            end else if (we2) begin
                if (wa2 !== ADDRBIT'(exp) || di2 !== '0) bad++;
                exp++;
                cnt++;
            end
            tick();
        end
        bus.init_start = 1'b0;
    endtask

    task automatic do_inc(input logic [ADDRBIT-1:0] a, input logic [INCBIT-1:0] v);
        logic acc;
        acc = 1'b0;
        bus.inc_vld = 1'b1; bus.inc_addr = a; bus.inc_val = v;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus.inc_rdy;
            tick();
        end
        bus.inc_vld = 1'b0;
    endtask

    // CPU access; lat is the number of cycles from request to ack, -1 on timeout.
    task automatic cpu_op(input logic [ADDRBIT-1:0] a, input logic clr,
                          output logic [WIDTH-1:0] d, output int lat);
        logic got;
        got = 1'b0; lat = -1; d = '0;
        bus.cpu_req = 1'b1; bus.cpu_clr = clr; bus.cpu_addr = a;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                got = 1'b1; d = bus.cpu_rdata; lat = n; bus.cpu_req = 1'b0;
            end
            tick();
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        int cnt, bad, lat;
        logic done;
        logic [WIDTH-1:0] d;
        rst_n = 1'b0; fill = 1'b1;
        tick();
        fill = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.inc_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_inc_rdy got %0b want 0", bus.inc_rdy); end
        n_tests++; if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== '0) begin n_fail++; $display("FAIL rst_cpu got ack %0b data %0h want 0 0", bus.cpu_ack, bus.cpu_rdata); end
        n_tests++; if (bus.init_busy !== 1'b1) begin n_fail++; $display("FAIL rst_init_busy got %0b want 1", bus.init_busy); end
        n_tests++; if ({re1, we1, we2, re2} !== 4'b0) begin n_fail++; $display("FAIL rst_enables got %b want 0000", {re1, we1, we2, re2}); end
        n_tests++; if ({ra1, wa1, wa2, ra2, di1, di2} !== '0) begin n_fail++; $display("FAIL rst_addr_data got %0h want 0", {ra1, wa1, wa2, ra2, di1, di2}); end
        tick();
        rst_n = 1'b1;
        wait_init(-1, cnt, bad, done);
        n_tests++; if (cnt !== DEPTH) begin n_fail++; $display("FAIL init_count got %0d want %0d", cnt, DEPTH); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL init_sweep got %0d bad writes want 0", bad); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL init_done got %0b want 1", done); end
        cpu_op(11'd5, 1'b0, d, lat);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL read5_data got %0h want 0", d); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL read5_lat got %0d want 2", lat); end
    endtask

    task automatic test_single_inc();
        int lat;
        logic [WIDTH-1:0] d;
        bus.inc_vld = 1'b1; bus.inc_addr = 11'd7; bus.inc_val = 16'd3;
        @(negedge clk);
        n_tests++; if (bus.inc_rdy !== 1'b1 || re1 !== 1'b1 || ra1 !== 11'd7) begin n_fail++; $display("FAIL inc7_issue got rdy %0b re1 %0b ra1 %0d want 1 1 7", bus.inc_rdy, re1, ra1); end
        tick();
        bus.inc_vld = 1'b0;
        @(negedge clk);
        n_tests++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL inc7_early_we1 got %0b want 0", we1); end
        tick();
        @(negedge clk);
        n_tests++; if (we1 !== 1'b1 || wa1 !== 11'd7 || di1 !== 32'd3) begin n_fail++; $display("FAIL inc7_write got we1 %0b wa1 %0d di1 %0h want 1 7 3", we1, wa1, di1); end
        tick(); tick(); tick();
        cpu_op(11'd7, 1'b0, d, lat);
        n_tests++; if (d !== 32'd3 || lat !== 2) begin n_fail++; $display("FAIL read7 got %0h lat %0d want 3 lat 2", d, lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [WIDTH-1:0] d;
        logic [ADDRBIT-1:0] addrs [3];
        logic [INCBIT-1:0]  vals  [3];
        for (int v = 1; v <= 4; v++) begin
            bus.inc_vld = 1'b1; bus.inc_addr = 11'd9; bus.inc_val = INCBIT'(v);
            @(negedge clk);
            n_tests++; if (bus.inc_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy%0d got %0b want 1", v, bus.inc_rdy); end
            tick();
        end
        bus.inc_vld = 1'b0;
        cpu_op(11'd9, 1'b0, d, lat);
        n_tests++; if (d !== 32'd10) begin n_fail++; $display("FAIL b2b_read9 got %0h want a", d); end
        addrs[0] = 11'd20; addrs[1] = 11'd21; addrs[2] = 11'd20;
        vals[0]  = 16'd1;  vals[1]  = 16'd5;  vals[2]  = 16'd2;
        for (int i = 0; i < 3; i++) begin
            bus.inc_vld = 1'b1; bus.inc_addr = addrs[i]; bus.inc_val = vals[i];
            tick();
        end
        bus.inc_vld = 1'b0;
        cpu_op(11'd20, 1'b0, d, lat);
        n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL fwd_old_read20 got %0h want 3", d); end
        cpu_op(11'd21, 1'b0, d, lat);
        n_tests++; if (d !== 32'd5) begin n_fail++; $display("FAIL fwd_old_read21 got %0h want 5", d); end
    endtask

    task automatic test_saturate();
        int lat;
        logic [WIDTH-1:0] d;
        bd_we = 1'b1; bd_addr = 11'd100; bd_data = 32'hFFFF_FFF0;
        tick();
        bd_addr = 11'd101; bd_data = 32'hFFFF_FFDE;
        tick();
        bd_we = 1'b0;
        tick(); tick();
        do_inc(11'd100, 16'h0020);
        cpu_op(11'd100, 1'b0, d, lat);
        n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_first got %0h want ffffffff", d); end
        do_inc(11'd100, 16'h0001);
        cpu_op(11'd100, 1'b0, d, lat);
        n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold got %0h want ffffffff", d); end
        do_inc(11'd101, 16'h0020);
        cpu_op(11'd101, 1'b0, d, lat);
        n_tests++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_below got %0h want fffffffe", d); end
        do_inc(11'd101, 16'h0001);
        do_inc(11'd101, 16'h0001);
        cpu_op(11'd101, 1'b1, d, lat);
        n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_edge_clr got %0h want ffffffff", d); end
        cpu_op(11'd101, 1'b0, d, lat);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL after_clr got %0h want 0", d); end
        do_inc(11'd102, 16'hFFFF);
        cpu_op(11'd102, 1'b0, d, lat);
        n_tests++; if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL zero_ext got %0h want ffff", d); end
    endtask

    task automatic test_starve();
        int lat, grants, lows, low_at, ack_at;
        logic [ADDRBIT-1:0] low_ra;
        logic [WIDTH-1:0] d, rd;
        grants = 0; lows = 0; low_at = -1; ack_at = -1; low_ra = '0; rd = '0;
        bus.inc_vld = 1'b1; bus.inc_addr = 11'd50; bus.inc_val = 16'd1;
        bus.cpu_req = 1'b1; bus.cpu_clr = 1'b1; bus.cpu_addr = 11'd9;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.inc_rdy) grants++;
            else begin lows++; low_at = c; low_ra = ra1; end
            if (bus.cpu_ack) begin rd = bus.cpu_rdata; ack_at = c; bus.cpu_req = 1'b0; end
            tick();
        end
        bus.inc_vld = 1'b0; bus.cpu_req = 1'b0;
        n_tests++; if (lows !== 1 || low_at !== 4) begin n_fail++; $display("FAIL starve_gap got %0d gaps at %0d want 1 at 4", lows, low_at); end
        n_tests++; if (low_ra !== 11'd9) begin n_fail++; $display("FAIL starve_ra1 got %0d want 9", low_ra); end
        n_tests++; if (ack_at !== 6 || rd !== 32'd10) begin n_fail++; $display("FAIL starve_ack got cycle %0d data %0h want 6 a", ack_at, rd); end
        cpu_op(11'd50, 1'b0, d, lat);
        n_tests++; if (d !== 32'd11 || grants !== 11) begin n_fail++; $display("FAIL starve_no_loss got %0d grants %0d want 11 11", d, grants); end
        do_inc(11'd9, 16'd1);
        cpu_op(11'd9, 1'b0, d, lat);
        n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL after_clr9 got %0h want 1", d); end
    endtask

    task automatic test_init_restart();
        int cnt, bad, lat;
        logic done;
        logic [WIDTH-1:0] d;
        bus.inc_vld = 1'b1; bus.inc_addr = 11'd60; bus.inc_val = 16'd5;
        tick(); tick();
        bus.inc_vld = 1'b0; bus.init_start = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.inc_rdy !== 1'b0) begin n_fail++; $display("FAIL init_start_rdy got %0b want 0", bus.inc_rdy); end
        n_tests++; if (we1 !== 1'b1 || wa1 !== 11'd60 || di1 !== 32'd5) begin n_fail++; $display("FAIL drain_wr0 got we1 %0b wa1 %0d di1 %0h want 1 60 5", we1, wa1, di1); end
        tick();
        bus.init_start = 1'b0;
        @(negedge clk);
        n_tests++; if (we1 !== 1'b1 || di1 !== 32'd10 || bus.init_busy !== 1'b1) begin n_fail++; $display("FAIL drain_wr1 got we1 %0b di1 %0h busy %0b want 1 a 1", we1, di1, bus.init_busy); end
        tick();
        wait_init(100, cnt, bad, done);
        n_tests++; if (cnt !== DEPTH || bad !== 0 || done !== 1'b1) begin n_fail++; $display("FAIL reinit got cnt %0d bad %0d done %0b want %0d 0 1", cnt, bad, done, DEPTH); end
        cpu_op(11'd60, 1'b0, d, lat);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reinit_read60 got %0h want 0", d); end
        cpu_op(11'd100, 1'b0, d, lat);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reinit_read100 got %0h want 0", d); end
    endtask

    task automatic test_reset_mid_init();
        int cnt, bad, lat;
        logic done;
        logic [WIDTH-1:0] d;
        do_inc(11'd70, 16'd4);
        bus.init_start = 1'b1;
        tick();
        bus.init_start = 1'b0;
        repeat (60) tick();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.init_busy !== 1'b1 || we2 !== 1'b0 || wa2 !== '0) begin n_fail++; $display("FAIL mid_rst got busy %0b we2 %0b wa2 %0d want 1 0 0", bus.init_busy, we2, wa2); end
        tick();
        rst_n = 1'b1;
        wait_init(-1, cnt, bad, done);
        n_tests++; if (cnt !== DEPTH || bad !== 0 || done !== 1'b1) begin n_fail++; $display("FAIL mid_rst_init got cnt %0d bad %0d done %0b want %0d 0 1", cnt, bad, done, DEPTH); end
        cpu_op(11'd70, 1'b0, d, lat);
        n_tests++; if (d !== 32'd0 || lat !== 2) begin n_fail++; $display("FAIL mid_rst_read got %0h lat %0d want 0 lat 2", d, lat); end
    endtask

    initial begin
        bus.inc_vld = 1'b0; bus.inc_addr = '0; bus.inc_val = '0;
        bus.cpu_req = 1'b0; bus.cpu_clr = 1'b0; bus.cpu_addr = '0;
        bus.init_start = 1'b0;
        rst_n = 1'b0; fill = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        test_reset();
        test_single_inc();
        test_back_to_back();
        test_saturate();
        test_starve();
        test_init_restart();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
